// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode front-end sequencing logic:
// controller state encoding and the opcodes that matter to it.
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STALL  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } ctrl_state_t;

  localparam logic [5:0] HALT_OP = 6'b111111;

  // Control-flow opcodes; these resolve in EX and arrive as ex_branch_taken.
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the sequencing controller (slave).
// Levels only, no handshake: every input is sampled each cycle and every output is valid every cycle.
interface fetch_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic [31:0]      ex_target;
  logic             hazard;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pc_redirect;
  logic [31:0]      redirect_addr;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_opcode, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_target,
    input  hazard, if_id_stall, if_id_flush, id_ex_bubble, pc_redirect,
           redirect_addr, halted, stall_count, flush_count
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_target,
    output hazard, if_id_stall, if_id_flush, id_ex_bubble, pc_redirect,
           redirect_addr, halted, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the load in EX and the sources of the ID instruction.
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);
  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Front-end sequencing controller: load-use stalls, EX-resolved redirects and halt drain.
// All pipeline-control outputs are combinational so they act on the same-cycle register update.
module fetch_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  fetch_hazard_ctrl_if.slave  bus,
  output ctrl_state_t         dbg_state
);
  localparam logic [3:0]       STALL_LOAD = 4'(STALL_CYCLES - 1);
  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  ctrl_state_t      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             hz, stl, fl, bub, redir, hlt, lu_cycle;

  hazard_detect u_hazard_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .load_use    (load_use)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hz       = 1'b0;
    stl      = 1'b0;
    fl       = 1'b0;
    bub      = 1'b0;
    redir    = 1'b0;
    hlt      = 1'b0;
    lu_cycle = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.ex_branch_taken) begin
          redir   = 1'b1;
          fl      = 1'b1;
          bub     = 1'b1;
          state_d = ST_FLUSH;
        end else if (load_use) begin
          hz       = 1'b1;
          stl      = 1'b1;
          bub      = 1'b1;
          lu_cycle = 1'b1;
          if (STALL_CYCLES > 1) begin
            cnt_d   = STALL_LOAD;
            state_d = ST_STALL;
          end
        end else if (bus.id_opcode == HALT_OP) begin
          hz      = 1'b1;
          fl      = 1'b1;
          cnt_d   = DRAIN_LOAD;
          state_d = ST_DRAIN;
        end
      end
      ST_STALL: begin
        // EX holds a bubble here, so ex_branch_taken cannot be genuine.
        hz       = 1'b1;
        stl      = 1'b1;
        bub      = 1'b1;
        lu_cycle = 1'b1;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RUN;
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_DRAIN: begin
        // A redirect from an older instruction still in EX cancels the halt.
        if (bus.ex_branch_taken) begin
          redir   = 1'b1;
          fl      = 1'b1;
          bub     = 1'b1;
          state_d = ST_FLUSH;
        end else begin
          hz    = 1'b1;
          fl    = 1'b1;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        hlt = 1'b1;
        hz  = 1'b1;
        fl  = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (lu_cycle && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (redir && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset forces every output low in the same cycle, whatever the state.
  assign bus.hazard        = hz & ~rst;
  assign bus.if_id_stall   = stl & ~rst;
  assign bus.if_id_flush   = fl & ~rst;
  assign bus.id_ex_bubble  = bub & ~rst;
  assign bus.pc_redirect   = redir & ~rst;
  assign bus.redirect_addr = (redir & ~rst) ? bus.ex_target : 32'd0;
  assign bus.halted        = hlt & ~rst;
  assign bus.stall_count   = rst ? '0 : stall_cnt_q;
  assign bus.flush_count   = rst ? '0 : flush_cnt_q;
  assign dbg_state         = state_q;

endmodule

// File: doc/fetch_hazard_ctrl.md
# fetch_hazard_ctrl

Pipeline sequencing controller for the fetch/decode front end. It detects load-use hazards between the decode and execute stages and applies branch/jump redirects resolved in execute. It also drains and halts the pipeline on a halt instruction. Its outputs drive the fetch stage's PC-hold (`hazard`) input, the IF/ID and ID/EX pipeline registers, and the PC redirect mux.

## Interface
- `STALL_CYCLES`, default 1: cycles the PC is held per load-use hazard (1 to 15).
- `DRAIN_CYCLES`, default 3: cycles after a halt decode before `halted` asserts (1 to 15).
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_opcode`  in  6  opcode of the instruction in ID.
- `id_rs`  in  5  rs field of the ID instruction.
- `id_rt`  in  5  rt field of the ID instruction.
- `id_uses_rt`  in  1  the ID instruction reads rt as a source.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_rt`  in  5  load destination register in EX.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump.
- `ex_target`  in  32  redirect address from EX.
- `hazard`  out  1  hold the PC; connects to fetch `hazard`.
- `if_id_stall`  out  1  hold the IF/ID register.
- `if_id_flush`  out  1  zero the IF/ID register.
- `id_ex_bubble`  out  1  insert a NOP into ID/EX.
- `pc_redirect`  out  1  select `redirect_addr` as the next PC.
- `redirect_addr`  out  32  equals `ex_target` whenever `pc_redirect`=1, else 0.
- `halted`  out  1  pipeline halted.
- `stall_count`  out  `CNT_W`  count of load-use stall cycles.
- `flush_count`  out  `CNT_W`  count of redirects.

## Operation
- States: RUN, STALL, FLUSH, DRAIN, HALTED.
- Load-use condition: `ex_mem_read` & `ex_rt`≠0 & (`ex_rt`==`id_rs` | (`id_uses_rt` & `ex_rt`==`id_rt`)).
- Halt condition: `id_opcode`==HALT_OP (6'b111111).
- Priority within a cycle: redirect > load-use > halt.
- RUN:
  - On `ex_branch_taken`: assert `pc_redirect`, `if_id_flush` and `id_ex_bubble` combinationally this cycle; go to FLUSH.
  - Else on load-use: assert `hazard`, `if_id_stall` and `id_ex_bubble` this cycle. If `STALL_CYCLES`>1, load the stall counter with `STALL_CYCLES`-1 and go to STALL; otherwise stay in RUN.
  - Else on halt: assert `hazard` and `if_id_flush`; load the drain counter with `DRAIN_CYCLES`; go to DRAIN.
- STALL: assert `hazard`, `if_id_stall` and `id_ex_bubble`. Decrement the counter; return to RUN when it reaches 0. A taken branch here is impossible, since EX holds a bubble; it is ignored.
- FLUSH: lasts one cycle. All outputs are 0 and hazard detection is suppressed, because ID holds a flushed NOP. Return to RUN.
- DRAIN: assert `hazard` and `if_id_flush`. Decrement the counter; at 0 go to HALTED. `ex_branch_taken` during DRAIN comes from an older instruction and takes effect:
  - assert redirect, flush and bubble;
  - abandon the halt;
  - go to FLUSH.
- HALTED: `halted`=1, `hazard`=1, `if_id_flush`=1. The block leaves HALTED only on `rst`.
- Counters:
  - `stall_count` increments on every cycle in which `hazard`=1 due to load-use (RUN detect or STALL).
  - `flush_count` increments on every cycle with `pc_redirect`=1.
  - Both saturate at all-ones; they do not wrap.

## Timing
- Every hazard, flush and redirect output is combinational from the current state and inputs, so it takes effect on the same-cycle PC and pipeline-register update (zero added latency).
- A load-use hazard costs exactly `STALL_CYCLES` PC-hold cycles.
- A redirect costs one flush cycle plus one FLUSH cycle.
- `halted` rises `DRAIN_CYCLES`+1 edges after the halt-detect cycle.
- Reset values: state RUN, counters 0, every output 0.
- `rst` has priority over all inputs in any state, including mid-STALL and mid-DRAIN. In the cycle `rst` is high, all outputs are forced to 0.

## Structure
- Shared package `pipe_pkg`:
  - `ctrl_state_t` enum for the five states;
  - `HALT_OP`;
  - opcode constants for the control-flow instructions.
- Natural sub-module `hazard_detect`: a purely combinational load-use comparator producing a single `load_use` bit. The FSM, counters and output decode stay in the top module.

## Test plan
- Load followed by a dependent instruction: `ex_mem_read`=1, `ex_rt`=5, `id_rs`=5, `STALL_CYCLES`=1 -> `hazard`/`if_id_stall`/`id_ex_bubble` high for 1 cycle, `stall_count`=1.
- Same hazard with `ex_rt`=0, or with `id_uses_rt`=0 and only rt matching -> no stall.
- `ex_branch_taken`=1, `ex_target`=0x40 -> `pc_redirect`=1 and `redirect_addr`=0x40 that cycle; next cycle all outputs 0 even if load-use inputs are asserted; `flush_count`=1.
- Load-use and `ex_branch_taken` in the same cycle -> redirect wins, `hazard`=0, `stall_count` unchanged.
- Halt opcode with `DRAIN_CYCLES`=3 -> `halted`=1 on the 4th edge; `rst` pulse -> `halted`=0, counters 0.
- `STALL_CYCLES`=4 with `rst` asserted on the 2nd stall cycle -> state RUN and all outputs 0 on the next cycle; `stall_count`=0.
